// File: rtl/shifter_pipe.sv
// shifter_pipe: parametrised, pipelined barrel shifter with valid/ready handshake.
// Shift amount is decomposed into log2(WIDTH) power-of-two mux levels; a
// register stage follows every LEVELS_PER_STAGE levels and the final level.
// A single global stall (in_ready) freezes every stage at once.
module shifter_pipe #(
  parameter int WIDTH            = 16,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         shift_in,
  input  logic [$clog2(WIDTH)-1:0] shift_val,
  input  logic [2:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         shift_out,
  output logic                     carry_out,
  output logic                     zero,
  output logic                     mode_err
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAT     = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Internal operation encoding; both ROR encodings collapse to OP_ROR.
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRA = 3'd1;
  localparam logic [2:0] OP_ROR = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_RSV = 3'd5;

  // Everything that travels down the pipe with an operand.
  typedef struct packed {
    logic [WIDTH-1:0]   data;   // partially shifted value
    logic [SHAMT_W-1:0] amt;    // full shift amount, each level picks its bit
    logic [2:0]         op;     // decoded operation
    logic               carry;  // last bit shifted out so far (shifts only)
  } slot_t;

  // Registered result presented on the outputs.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
    logic             err;
  } res_t;

  logic             advance;
  logic [LAT-1:0]   valid_q;
  slot_t            in_slot;
  slot_t            fin;
  res_t             res_d;
  res_t             res_q;

  // Global stall: every stage moves together or not at all.
  assign out_valid = valid_q[LAT-1];
  assign in_ready  = !out_valid || out_ready;
  assign advance   = in_ready;

  // Decode the external mode into the internal op and build the level-0 slot.
  always_comb begin
    in_slot       = '0;
    in_slot.data  = shift_in;
    in_slot.amt   = shift_val;
    in_slot.carry = 1'b0;
    case (mode)
      3'b000:         in_slot.op = OP_SLL;
      3'b001:         in_slot.op = OP_SRA;
      3'b010, 3'b011: in_slot.op = OP_ROR;
      3'b100:         in_slot.op = OP_SRL;
      3'b101:         in_slot.op = OP_ROL;
      default:        in_slot.op = OP_RSV;
    endcase
  end

  // Mux levels: level k shifts by 2^k when amt[k] is set.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    localparam int SH = 1 << k;
    slot_t lvl_in;
    slot_t lvl_out;

    if (k == 0) begin : g_src
      assign lvl_in = in_slot;
    end else if ((k % LEVELS_PER_STAGE) == 0) begin : g_src
      assign lvl_in = g_mid[(k / LEVELS_PER_STAGE) - 1].slot_q;
    end else begin : g_src
      assign lvl_in = g_lvl[k-1].lvl_out;
    end

    // Apply this level's power-of-two shift/rotate; the carry left by the
    // last level that actually shifts is the last bit shifted out overall.
    // SRA fills with the current MSB, which always equals the original
    // shift_in MSB because every earlier SRA level preserved it.
    always_comb begin
      // NOTE: copy the input first so every path assigns lvl_out; without
      // this default the unlisted cases would infer a latch.
      lvl_out = lvl_in;
      if (lvl_in.amt[k]) begin
        case (lvl_in.op)
          OP_SLL: begin
            lvl_out.data  = {lvl_in.data[WIDTH-SH-1:0], {SH{1'b0}}};
            lvl_out.carry = lvl_in.data[WIDTH-SH];
          end
          OP_SRA: begin
            lvl_out.data  = {{SH{lvl_in.data[WIDTH-1]}}, lvl_in.data[WIDTH-1:SH]};
            lvl_out.carry = lvl_in.data[SH-1];
          end
          OP_SRL: begin
            lvl_out.data  = {{SH{1'b0}}, lvl_in.data[WIDTH-1:SH]};
            lvl_out.carry = lvl_in.data[SH-1];
          end
          OP_ROR: begin
            lvl_out.data  = {lvl_in.data[SH-1:0], lvl_in.data[WIDTH-1:SH]};
          end
          OP_ROL: begin
            lvl_out.data  = {lvl_in.data[WIDTH-SH-1:0], lvl_in.data[WIDTH-1:WIDTH-SH]};
          end
          default: begin
            // Reserved op: operand passes through untouched.
          end
        endcase
      end
    end
  end

  // Intermediate register stages; the last stage is the result register below.
  for (genvar s = 0; s < LAT - 1; s++) begin : g_mid
    localparam int SRC = (s + 1) * LEVELS_PER_STAGE - 1;
    slot_t slot_q;

    // Capture the slot leaving this stage's last mux level on each advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_q <= '0;
      end else if (advance) begin
        // NOTE: non-blocking so each stage loads the value its neighbour held
        // before the edge, independent of block evaluation order.
        slot_q <= g_lvl[SRC].lvl_out;
      end
    end
  end

  // Valid bits shift alongside the data; a cleared bit is a bubble.
  if (LAT > 1) begin : g_vld
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
      end else if (advance) begin
        valid_q <= {valid_q[LAT-2:0], in_valid};
      end
    end
  end else begin : g_vld
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
      end else if (advance) begin
        valid_q <= in_valid;
      end
    end
  end

  assign fin = g_lvl[SHAMT_W-1].lvl_out;

  // Resolve flags on the fully shifted value: rotate carries come from the
  // result itself, reserved ops report an error and no carry.
  always_comb begin
    res_d       = '0;
    res_d.data  = fin.data;
    res_d.carry = fin.carry;
    res_d.err   = 1'b0;
    case (fin.op)
      OP_ROR:  res_d.carry = (|fin.amt) & fin.data[WIDTH-1];
      OP_ROL:  res_d.carry = (|fin.amt) & fin.data[0];
      OP_RSV: begin
        res_d.carry = 1'b0;
        res_d.err   = 1'b1;
      end
      default: begin
        // Shifts already carry the correct bit from the levels.
      end
    endcase
    res_d.zero = (fin.data == '0);
  end

  // Result register; held while the consumer is stalling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data path is reset as well as the valid bits, so shift_out
      // and the flags read 0 immediately on reset rather than stale values.
      res_q <= '0;
    end else if (advance) begin
      res_q <= res_d;
    end
  end

  assign shift_out = res_q.data;
  assign carry_out = res_q.carry;
  assign zero      = res_q.zero;
  assign mode_err  = res_q.err;

endmodule
